// File: rtl/branch_unit_pkg.sv
// Shared encodings for the program-sequencing stage: op and condition codes,
// flag bit positions, FSM states and the condition evaluator.
package branch_unit_pkg;

   localparam logic [2:0] OP_NOP  = 3'd0;
   localparam logic [2:0] OP_JMP  = 3'd1;
   localparam logic [2:0] OP_CALL = 3'd2;
   localparam logic [2:0] OP_RET  = 3'd3;

   localparam logic [3:0] CC_ALWAYS = 4'd0;
   localparam logic [3:0] CC_Z      = 4'd1;
   localparam logic [3:0] CC_NZ     = 4'd2;
   localparam logic [3:0] CC_C      = 4'd3;
   localparam logic [3:0] CC_NC     = 4'd4;
   localparam logic [3:0] CC_S      = 4'd5;
   localparam logic [3:0] CC_NS     = 4'd6;
   localparam logic [3:0] CC_O      = 4'd7;
   localparam logic [3:0] CC_NO     = 4'd8;
   localparam logic [3:0] CC_LT     = 4'd9;
   localparam logic [3:0] CC_GE     = 4'd10;
   localparam logic [3:0] CC_LEU    = 4'd11;
   localparam logic [3:0] CC_GTU    = 4'd12;

   localparam int FZ = 0;
   localparam int FC = 1;
   localparam int FS = 2;
   localparam int FO = 3;

   typedef enum logic [1:0] {
      ST_RUN   = 2'd0,
      ST_FLUSH = 2'd1,
      ST_ERR   = 2'd2
   } state_t;

   // Codes 13-15 fall through to the default and never take.
   function automatic logic cond_true(input logic [3:0] cc, input logic [3:0] flags);
      logic z, c, s, o, res;
      z = flags[FZ];
      c = flags[FC];
      s = flags[FS];
      o = flags[FO];
      case (cc)
         CC_ALWAYS: res = 1'b1;
         CC_Z:      res = z;
         CC_NZ:     res = !z;
         CC_C:      res = c;
         CC_NC:     res = !c;
         CC_S:      res = s;
         CC_NS:     res = !s;
         CC_O:      res = o;
         CC_NO:     res = !o;
         CC_LT:     res = s ^ o;
         CC_GE:     res = !(s ^ o);
         CC_LEU:    res = c | z;
         CC_GTU:    res = !(c | z);
         default:   res = 1'b0;
      endcase
      return res;
   endfunction

endpackage

// File: rtl/branch_unit_if.sv
// Decoded control-flow request and fetch-side results of the branch unit.
interface branch_unit_if #(
   parameter int AW = 8,
   parameter int SD = 4
);
   localparam int SPW = $clog2(SD + 1);

   logic          stall;
   logic          en;
   logic [2:0]    op;
   logic [3:0]    cc;
   logic [AW-1:0] target;
   logic [3:0]    flags;
   logic [AW-1:0] pc;
   logic          taken;
   logic          flush;
   logic          err;
   logic [SPW-1:0] sp;

   modport master (
      output stall, en, op, cc, target, flags,
      input  pc, taken, flush, err, sp
   );

   modport slave (
      input  stall, en, op, cc, target, flags,
      output pc, taken, flush, err, sp
   );

endinterface

// File: rtl/branch_unit_ret_stack.sv
// Return-address LIFO: synchronous push/pop, combinational top-of-stack read.
module ret_stack #(
   parameter int W = 8,
   parameter int D = 4
) (
   input  logic                     clk,
   input  logic                     r,
   input  logic                     push,
   input  logic                     pop,
   input  logic [W-1:0]             din,
   output logic [W-1:0]             top,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(D+1)-1:0]   count
);
   localparam int CW = $clog2(D + 1);
   localparam int IW = (D > 1) ? $clog2(D) : 1;

   logic [W-1:0]  mem [D];
   logic [CW-1:0] cnt;
   logic [IW-1:0] wr_idx;
   logic [IW-1:0] top_idx;

   assign wr_idx  = cnt[IW-1:0];
   assign top_idx = IW'(cnt - CW'(1));
   assign full    = (cnt == CW'(D));
   assign empty   = (cnt == '0);
   assign count   = cnt;
   assign top     = empty ? '0 : mem[top_idx];

   // Entries carry no reset; only the occupancy count defines what is valid.
   always_ff @(posedge clk) begin
      if (push && !full) mem[wr_idx] <= din;
   end

   always_ff @(posedge clk or negedge r) begin
      if (!r)                  cnt <= '0;
      else if (push && !full)  cnt <= cnt + CW'(1);
      else if (pop && !empty)  cnt <= cnt - CW'(1);
   end

endmodule

// File: rtl/branch_unit.sv
// Program sequencer: evaluates the condition code against the registered flags
// and steers the fetch PC through jump, call and return with a flush pulse.
module branch_unit
   import branch_unit_pkg::*;
#(
   parameter int AW = 8,
   parameter int SD = 4
) (
   input logic          clk,
   input logic          r,
   branch_unit_if.slave bus
);
   localparam int SPW = $clog2(SD + 1);

   state_t         state;
   logic [AW-1:0]  pc_val;
   logic [AW-1:0]  pc_inc;
   logic           taken_val;
   logic           flush_val;
   logic           err_val;
   logic [AW-1:0]  stk_top;
   logic           stk_full;
   logic           stk_empty;
   logic [SPW-1:0] stk_count;
   logic           active;
   logic           cond_ok;
   logic           do_jmp;
   logic           do_call;
   logic           do_ret;
   logic           push;
   logic           pop;
   logic           fault;
   logic           transfer;

   assign pc_inc = pc_val + AW'(1);

   // A request only counts in RUN with no stall; a stack fault replaces the transfer.
   always_comb begin
      active   = (state == ST_RUN) && !bus.stall && bus.en;
      cond_ok  = cond_true(bus.cc, bus.flags);
      do_jmp   = active && cond_ok && (bus.op == OP_JMP);
      do_call  = active && cond_ok && (bus.op == OP_CALL);
      do_ret   = active && cond_ok && (bus.op == OP_RET);
      push     = do_call && !stk_full;
      pop      = do_ret && !stk_empty;
      fault    = (do_call && stk_full) || (do_ret && stk_empty);
      transfer = do_jmp || push || pop;
   end

   ret_stack #(.W(AW), .D(SD)) u_stack (
      .clk   (clk),
      .r     (r),
      .push  (push),
      .pop   (pop),
      .din   (pc_inc),
      .top   (stk_top),
      .full  (stk_full),
      .empty (stk_empty),
      .count (stk_count)
   );

   // Flush rises on the cycle after taken and stays up while FLUSH is stalled.
   always_ff @(posedge clk or negedge r) begin
      if (!r) begin
         state     <= ST_RUN;
         pc_val    <= '0;
         taken_val <= 1'b0;
         flush_val <= 1'b0;
         err_val   <= 1'b0;
      end else begin
         case (state)
            ST_RUN: begin
               taken_val <= 1'b0;
               flush_val <= 1'b0;
               if (!bus.stall) begin
                  if (fault) begin
                     err_val <= 1'b1;
                     state   <= ST_ERR;
                  end else if (transfer) begin
                     taken_val <= 1'b1;
                     state     <= ST_FLUSH;
                     pc_val    <= pop ? stk_top : bus.target;
                  end else begin
                     pc_val <= pc_inc;
                  end
               end
            end
            ST_FLUSH: begin
               taken_val <= 1'b0;
               flush_val <= 1'b1;
               if (!bus.stall) state <= ST_RUN;
            end
            ST_ERR: begin
               taken_val <= 1'b0;
               flush_val <= 1'b0;
               err_val   <= 1'b1;
            end
            default: state <= ST_RUN;
         endcase
      end
   end

   assign bus.pc    = pc_val;
   assign bus.taken = taken_val;
   assign bus.flush = flush_val;
   assign bus.err   = err_val;
   assign bus.sp    = stk_count;

endmodule

// File: tb/tb_branch_unit.sv
// Directed bench for branch_unit: a vector table from reset, then hand-written
// stack, error and asynchronous-reset sequences.
module tb_branch_unit;
   import branch_unit_pkg::*;

   typedef struct {
      logic       stall;
      logic       en;
      logic [2:0] op;
      logic [3:0] cc;
      logic [7:0] target;
      logic [3:0] flags;
      logic [7:0] pc;
      logic       taken;
      logic       flush;
      logic       err;
      logic [2:0] sp;
   } vec_t;

   logic clk;
   logic r;
   int   checks;
   int   errors;
   vec_t vecs[$];

   branch_unit_if #(.AW(8), .SD(4)) bus ();

   branch_unit #(.AW(8), .SD(4)) dut (
      .clk (clk),
      .r   (r),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: run still active at %0t, required finish", $time);
      $fatal(1, "[TB] watchdog expired");
   end

   function automatic vec_t mk(input logic st, input logic e, input logic [2:0] o,
                               input logic [3:0] c, input logic [7:0] t, input logic [3:0] f,
                               input logic [7:0] p, input logic tk, input logic fl,
                               input logic er, input logic [2:0] s);
      vec_t v;
      v.stall = st; v.en = e; v.op = o; v.cc = c; v.target = t; v.flags = f;
      v.pc = p; v.taken = tk; v.flush = fl; v.err = er; v.sp = s;
      return v;
   endfunction

   task automatic applyStimulus(input logic st, input logic e, input logic [2:0] o,
                                input logic [3:0] c, input logic [7:0] t, input logic [3:0] f);
      bus.stall  = st;
      bus.en     = e;
      bus.op     = o;
      bus.cc     = c;
      bus.target = t;
      bus.flags  = f;
   endtask

   task automatic checkOutput(input string name, input logic [7:0] p, input logic tk,
                              input logic fl, input logic er, input logic [2:0] s);
      checks++;
      if (bus.pc !== p || bus.taken !== tk || bus.flush !== fl || bus.err !== er || bus.sp !== s) begin
         errors++;
         $display("[TB] FAIL %s: got pc=%02h taken=%b flush=%b err=%b sp=%0d, want pc=%02h taken=%b flush=%b err=%b sp=%0d",
                  name, bus.pc, bus.taken, bus.flush, bus.err, bus.sp, p, tk, fl, er, s);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      applyStimulus(1'b0, 1'b0, OP_NOP, CC_ALWAYS, 8'h00, 4'h0);
   endtask

   // Reset is asserted between clock edges so the check proves it is asynchronous.
   task automatic doReset(input string name);
      r = 1'b1;
      idle();
      #1;
      r = 1'b0;
      #1;
      checkOutput(name, 8'h00, 1'b0, 1'b0, 1'b0, 3'd0);
      step();
      r = 1'b1;
   endtask

   task automatic edgeCheck(input string name, input logic [7:0] p, input logic tk,
                            input logic fl, input logic er, input logic [2:0] s);
      step();
      checkOutput(name, p, tk, fl, er, s);
   endtask

   initial begin
      checks = 0;
      errors = 0;
      r      = 1'b1;
      idle();

      for (int i = 1; i <= 5; i++)
         vecs.push_back(mk(0, 0, OP_NOP, CC_ALWAYS, 8'h00, 4'h0, 8'(i), 0, 0, 0, 0));
      vecs.push_back(mk(0, 1, OP_JMP,  CC_Z,      8'h40, 4'h0, 8'h06, 0, 0, 0, 0));
      vecs.push_back(mk(0, 1, OP_JMP,  CC_NZ,     8'h40, 4'h0, 8'h40, 1, 0, 0, 0));
      vecs.push_back(mk(0, 1, OP_JMP,  CC_ALWAYS, 8'h99, 4'h0, 8'h40, 0, 1, 0, 0));
      vecs.push_back(mk(0, 0, OP_NOP,  CC_ALWAYS, 8'h00, 4'h0, 8'h41, 0, 0, 0, 0));
      vecs.push_back(mk(0, 1, OP_JMP,  CC_Z,      8'h50, 4'h1, 8'h50, 1, 0, 0, 0));
      vecs.push_back(mk(0, 0, OP_NOP,  CC_ALWAYS, 8'h00, 4'h0, 8'h50, 0, 1, 0, 0));
      vecs.push_back(mk(0, 0, OP_NOP,  CC_ALWAYS, 8'h00, 4'h0, 8'h51, 0, 0, 0, 0));
      vecs.push_back(mk(0, 1, OP_CALL, CC_ALWAYS, 8'h20, 4'h0, 8'h20, 1, 0, 0, 1));
      vecs.push_back(mk(0, 0, OP_NOP,  CC_ALWAYS, 8'h00, 4'h0, 8'h20, 0, 1, 0, 1));
      vecs.push_back(mk(0, 0, OP_NOP,  CC_ALWAYS, 8'h00, 4'h0, 8'h21, 0, 0, 0, 1));
      vecs.push_back(mk(0, 1, OP_RET,  CC_ALWAYS, 8'h99, 4'h0, 8'h52, 1, 0, 0, 0));
      vecs.push_back(mk(0, 0, OP_NOP,  CC_ALWAYS, 8'h00, 4'h0, 8'h52, 0, 1, 0, 0));
      vecs.push_back(mk(0, 0, OP_NOP,  CC_ALWAYS, 8'h00, 4'h0, 8'h53, 0, 0, 0, 0));
      vecs.push_back(mk(0, 1, OP_JMP,  4'd13,     8'h99, 4'hF, 8'h54, 0, 0, 0, 0));
      vecs.push_back(mk(0, 1, OP_JMP,  CC_LT,     8'h99, 4'hC, 8'h55, 0, 0, 0, 0));
      vecs.push_back(mk(0, 1, OP_JMP,  CC_GTU,    8'h99, 4'h1, 8'h56, 0, 0, 0, 0));
      vecs.push_back(mk(0, 1, OP_JMP,  CC_LEU,    8'hFD, 4'h1, 8'hFD, 1, 0, 0, 0));
      vecs.push_back(mk(0, 0, OP_NOP,  CC_ALWAYS, 8'h00, 4'h0, 8'hFD, 0, 1, 0, 0));
      vecs.push_back(mk(0, 0, OP_NOP,  CC_ALWAYS, 8'h00, 4'h0, 8'hFE, 0, 0, 0, 0));
      vecs.push_back(mk(0, 0, OP_NOP,  CC_ALWAYS, 8'h00, 4'h0, 8'hFF, 0, 0, 0, 0));
      vecs.push_back(mk(0, 0, OP_NOP,  CC_ALWAYS, 8'h00, 4'h0, 8'h00, 0, 0, 0, 0));
      vecs.push_back(mk(0, 1, 3'd5,    CC_ALWAYS, 8'h99, 4'h0, 8'h01, 0, 0, 0, 0));
      vecs.push_back(mk(1, 1, OP_JMP,  CC_ALWAYS, 8'h30, 4'h0, 8'h01, 0, 0, 0, 0));
      vecs.push_back(mk(0, 1, OP_JMP,  CC_ALWAYS, 8'h30, 4'h0, 8'h30, 1, 0, 0, 0));
      vecs.push_back(mk(1, 0, OP_NOP,  CC_ALWAYS, 8'h00, 4'h0, 8'h30, 0, 1, 0, 0));
      vecs.push_back(mk(0, 0, OP_NOP,  CC_ALWAYS, 8'h00, 4'h0, 8'h30, 0, 1, 0, 0));
      vecs.push_back(mk(0, 0, OP_NOP,  CC_ALWAYS, 8'h00, 4'h0, 8'h31, 0, 0, 0, 0));
      vecs.push_back(mk(0, 1, OP_CALL, CC_Z,      8'h99, 4'h0, 8'h32, 0, 0, 0, 0));
      vecs.push_back(mk(0, 1, OP_JMP,  CC_GE,     8'h99, 4'h8, 8'h33, 0, 0, 0, 0));
      vecs.push_back(mk(0, 1, OP_JMP,  CC_S,      8'h70, 4'h4, 8'h70, 1, 0, 0, 0));
      vecs.push_back(mk(0, 0, OP_NOP,  CC_ALWAYS, 8'h00, 4'h0, 8'h70, 0, 1, 0, 0));
      vecs.push_back(mk(0, 0, OP_NOP,  CC_ALWAYS, 8'h00, 4'h0, 8'h71, 0, 0, 0, 0));

      doReset("reset_initial");
      foreach (vecs[i]) begin
         applyStimulus(vecs[i].stall, vecs[i].en, vecs[i].op, vecs[i].cc, vecs[i].target, vecs[i].flags);
         edgeCheck($sformatf("vec%0d", i), vecs[i].pc, vecs[i].taken, vecs[i].flush, vecs[i].err, vecs[i].sp);
      end

      // Nested call/return: returns must come back in LIFO order.
      doReset("reset_nested");
      applyStimulus(0, 1, OP_CALL, CC_ALWAYS, 8'h50, 4'h0);
      edgeCheck("nest_call1", 8'h50, 1, 0, 0, 3'd1);
      idle();
      edgeCheck("nest_flush1", 8'h50, 0, 1, 0, 3'd1);
      applyStimulus(0, 1, OP_CALL, CC_ALWAYS, 8'h60, 4'h0);
      edgeCheck("nest_call2", 8'h60, 1, 0, 0, 3'd2);
      idle();
      edgeCheck("nest_flush2", 8'h60, 0, 1, 0, 3'd2);
      applyStimulus(0, 1, OP_RET, CC_ALWAYS, 8'h00, 4'h0);
      edgeCheck("nest_ret1", 8'h51, 1, 0, 0, 3'd1);
      idle();
      edgeCheck("nest_flush3", 8'h51, 0, 1, 0, 3'd1);
      applyStimulus(0, 1, OP_RET, CC_ALWAYS, 8'h00, 4'h0);
      edgeCheck("nest_ret2", 8'h01, 1, 0, 0, 3'd0);
      idle();
      edgeCheck("nest_flush4", 8'h01, 0, 1, 0, 3'd0);

      // Fill the stack, then a fifth call must fault and freeze everything.
      for (int i = 0; i < 4; i++) begin
         applyStimulus(0, 1, OP_CALL, CC_ALWAYS, 8'(8'h10 * (i + 1)), 4'h0);
         edgeCheck($sformatf("ovf_call%0d", i), 8'(8'h10 * (i + 1)), 1, 0, 0, 3'(i + 1));
         idle();
         edgeCheck($sformatf("ovf_flush%0d", i), 8'(8'h10 * (i + 1)), 0, 1, 0, 3'(i + 1));
      end
      applyStimulus(0, 1, OP_CALL, CC_ALWAYS, 8'hAA, 4'h0);
      edgeCheck("ovf_fault", 8'h40, 0, 0, 1, 3'd4);
      applyStimulus(0, 1, OP_JMP, CC_ALWAYS, 8'h99, 4'h0);
      edgeCheck("err_jmp_frozen", 8'h40, 0, 0, 1, 3'd4);
      applyStimulus(0, 1, OP_RET, CC_ALWAYS, 8'h00, 4'h0);
      edgeCheck("err_ret_frozen", 8'h40, 0, 0, 1, 3'd4);
      idle();
      edgeCheck("err_idle_frozen", 8'h40, 0, 0, 1, 3'd4);

      // Underflow: a false RET is harmless, a true RET on an empty stack faults.
      doReset("reset_from_err");
      applyStimulus(0, 1, OP_RET, CC_Z, 8'h00, 4'h0);
      edgeCheck("unf_false", 8'h01, 0, 0, 0, 3'd0);
      applyStimulus(0, 1, OP_RET, CC_ALWAYS, 8'h00, 4'h0);
      edgeCheck("unf_fault", 8'h01, 0, 0, 1, 3'd0);

      // Asynchronous reset while a stalled FLUSH holds flush high.
      doReset("reset_pre_flush");
      applyStimulus(0, 1, OP_JMP, CC_ALWAYS, 8'h80, 4'h0);
      edgeCheck("aflush_jmp", 8'h80, 1, 0, 0, 3'd0);
      applyStimulus(1, 0, OP_NOP, CC_ALWAYS, 8'h00, 4'h0);
      edgeCheck("aflush_hold", 8'h80, 0, 1, 0, 3'd0);
      #2;
      r = 1'b0;
      #1;
      checkOutput("aflush_async", 8'h00, 0, 0, 0, 3'd0);
      step();
      r = 1'b1;
      idle();
      edgeCheck("aflush_resume", 8'h01, 0, 0, 0, 3'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
